// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: turns START/WRITE/READ/STOP commands into open-drain
// SCL/SDA drive enables, timed by a quarter-bit tick counted from clk_in.
module i2c_master_byte #(
  parameter int unsigned QUARTER = 75,
  parameter int unsigned CNT_W   = 9
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] tx_data,
  input  logic       tx_nack,
  output logic [7:0] rx_data,
  output logic       rx_ack,
  output logic       done,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP
  } state_t;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [CNT_W-1:0] Q_LAST = CNT_W'(QUARTER - 1);

  state_t           state;
  logic [CNT_W-1:0] qcnt;
  logic [1:0]       phase;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             is_read;
  logic             nack_q;
  logic             tick_c;
  logic             last_c;

  assign tick_c = busy && (qcnt == Q_LAST);
  // Final quarter of a command: START, STOP or the ACK slot of a byte.
  assign last_c = tick_c && (phase == 2'd3) &&
                  ((state == S_START) || (state == S_STOP) || (state == S_ACK));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      qcnt      <= '0;
      phase     <= 2'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      is_read   <= 1'b0;
      nack_q    <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_data   <= 8'h00;
      rx_ack    <= 1'b1;
    end else begin
      done <= 1'b0;
      if (cmd_valid && cmd_ready) begin
        // Accept: latch operands and set up the q0 line levels right away.
        cmd_ready <= 1'b0;
        busy      <= 1'b1;
        qcnt      <= '0;
        phase     <= 2'd0;
        bit_cnt   <= 3'd7;
        shreg     <= tx_data;
        nack_q    <= tx_nack;
        is_read   <= (cmd == CMD_READ);
        case (cmd)
          CMD_START: begin
            state  <= S_START;
            sda_oe <= 1'b0;
          end
          CMD_WRITE: begin
            state  <= S_BIT;
            scl_oe <= 1'b1;
            sda_oe <= ~tx_data[7];
          end
          CMD_READ: begin
            state  <= S_BIT;
            scl_oe <= 1'b1;
            sda_oe <= 1'b0;
          end
          default: begin
            state  <= S_STOP;
            scl_oe <= 1'b1;
            sda_oe <= 1'b1;
          end
        endcase
      end else if (busy) begin
        qcnt <= tick_c ? '0 : qcnt + CNT_W'(1);
        if (last_c) begin
          state     <= S_IDLE;
          phase     <= 2'd0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b1;
          if ((state == S_ACK) && is_read) rx_data <= shreg;
        end else if (tick_c) begin
          // Each case arm sets the line levels of the quarter being entered.
          phase <= phase + 2'd1;
          case (state)
            S_START: begin
              case (phase)
                2'd0:    scl_oe <= 1'b0;
                2'd1:    sda_oe <= 1'b1;
                default: scl_oe <= 1'b1;
              endcase
            end
            S_BIT: begin
              case (phase)
                2'd0: scl_oe <= 1'b0;
                2'd1: if (is_read) shreg <= {shreg[6:0], sda_in};
                2'd2: scl_oe <= 1'b1;
                default: begin
                  if (bit_cnt == 3'd0) begin
                    state  <= S_ACK;
                    sda_oe <= is_read ? ~nack_q : 1'b0;
                  end else begin
                    bit_cnt <= bit_cnt - 3'd1;
                    if (is_read) begin
                      sda_oe <= 1'b0;
                    end else begin
                      shreg  <= {shreg[6:0], 1'b0};
                      sda_oe <= ~shreg[6];
                    end
                  end
                end
              endcase
            end
            S_ACK: begin
              case (phase)
                2'd0:    scl_oe <= 1'b0;
                2'd1:    if (!is_read) rx_ack <= sda_in;
                default: scl_oe <= 1'b1;
              endcase
            end
            S_STOP: begin
              case (phase)
                2'd0:    scl_oe <= 1'b0;
                2'd2:    sda_oe <= 1'b0;
                default: ;
              endcase
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: directed command table plus random commands, each
// checked quarter by quarter against a waveform model of the I2C bus.
`timescale 1ns/1ps
module tb_i2c_master_byte;

  localparam int unsigned Q = 4;
  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_WRITE = 2'b01;
  localparam logic [1:0] C_READ  = 2'b10;
  localparam logic [1:0] C_STOP  = 2'b11;

  logic       clk_in    = 1'b0;
  logic       rst_n     = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd       = 2'b00;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_nack   = 1'b0;
  logic       sda_in    = 1'b1;
  logic       cmd_ready, rx_ack, done, busy, scl_oe, sda_oe;
  logic [7:0] rx_data;

  int checks = 0;
  int errors = 0;

  i2c_master_byte #(.QUARTER(Q), .CNT_W(3)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .tx_data   (tx_data),
    .tx_nack   (tx_nack),
    .rx_data   (rx_data),
    .rx_ack    (rx_ack),
    .done      (done),
    .busy      (busy),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .sda_in    (sda_in)
  );

  always #5 clk_in = ~clk_in;

  // Model of the bus and of the result registers
  logic       m_scl, m_sda, m_rx_ack;
  logic [7:0] m_rx_data;
  int         got_lat;

  typedef struct {
    logic [1:0] c;
    logic [7:0] d;
    logic       nk;
    logic [7:0] sb;
    logic       sa;
    logic       hold;
    int         lat;
    logic [7:0] rxd;
    logic       rxa;
    logic [1:0] lines;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scl     = 1'b0;
    m_sda     = 1'b0;
    m_rx_ack  = 1'b1;
    m_rx_data = 8'h00;
  endtask

  // One command: build the expected per-quarter {scl_oe,sda_oe} list and the
  // slave's SDA level per quarter, then drive, watch and compare.
  task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input logic nk,
                         input logic [7:0] sb, input logic sa, input logic hold);
    logic [1:0] wave[$];
    logic       lvl[$];
    int         lat;
    int         n;
    int         w;
    logic       b;
    case (c)
      C_START: begin
        wave.push_back({m_scl, 1'b0});
        wave.push_back(2'b00);
        wave.push_back(2'b01);
        wave.push_back(2'b11);
        repeat (4) lvl.push_back(1'b1);
      end
      C_WRITE, C_READ: begin
        for (int i = 7; i >= 0; i--) begin
          b = (c == C_WRITE) ? ~d[i] : 1'b0;
          wave.push_back({1'b1, b});
          wave.push_back({1'b0, b});
          wave.push_back({1'b0, b});
          wave.push_back({1'b1, b});
          if (c == C_READ) begin
            repeat (3) lvl.push_back(sb[i]);
            lvl.push_back(~sb[i]);
          end else begin
            repeat (4) lvl.push_back(1'b1);
          end
        end
        b = (c == C_WRITE) ? 1'b0 : ~nk;
        wave.push_back({1'b1, b});
        wave.push_back({1'b0, b});
        wave.push_back({1'b0, b});
        wave.push_back({1'b1, b});
        if (c == C_WRITE) begin
          repeat (3) lvl.push_back(sa);
          lvl.push_back(~sa);
        end else begin
          repeat (4) lvl.push_back(1'b1);
        end
      end
      default: begin
        wave.push_back(2'b11);
        wave.push_back(2'b01);
        wave.push_back(2'b01);
        wave.push_back(2'b00);
        repeat (4) lvl.push_back(1'b1);
      end
    endcase
    lat = wave.size() * int'(Q) + 1;

    w = 0;
    while (!cmd_ready && w < 10) begin
      @(posedge clk_in); #1;
      w++;
    end
    chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd = c; tx_data = d; tx_nack = nk; cmd_valid = 1'b1;
    @(posedge clk_in); #1;
    if (hold) begin
      cmd = C_WRITE; tx_data = ~d; tx_nack = ~nk;
    end else begin
      cmd_valid = 1'b0;
    end

    got_lat = -1;
    for (int cyc = 1; cyc <= lat + 8; cyc++) begin
      if (done) begin
        got_lat = cyc;
        break;
      end
      n = (cyc - 1) / int'(Q);
      if (n < wave.size()) begin
        if ((cyc - 1) % int'(Q) == 0) sda_in = lvl[n];
        if ((cyc - 1) % int'(Q) == 1)
          chk($sformatf("wave_cmd%0d_q%0d", c, n), 32'({scl_oe, sda_oe}), 32'(wave[n]));
      end
      @(posedge clk_in); #1;
    end
    cmd_valid = 1'b0;
    sda_in    = 1'b1;

    if (c == C_READ)  m_rx_data = sb;
    if (c == C_WRITE) m_rx_ack  = sa;
    {m_scl, m_sda} = wave[$];
    chk("latency", 32'(got_lat), 32'(lat));
    chk("done_cycle", 32'({done, cmd_ready, busy}), 32'b110);
    chk("rx_data", 32'(rx_data), 32'(m_rx_data));
    chk("rx_ack", 32'(rx_ack), 32'(m_rx_ack));
    @(posedge clk_in); #1;
    chk("idle_after", 32'({done, cmd_ready, busy, scl_oe, sda_oe}),
        32'({1'b0, 1'b1, 1'b0, m_scl, m_sda}));
  endtask

  initial begin
    vecs[0] = '{C_START, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0,  17, 8'h00, 1'b1, 2'b11};
    vecs[1] = '{C_STOP,  8'h00, 1'b0, 8'h00, 1'b1, 1'b0,  17, 8'h00, 1'b1, 2'b00};
    vecs[2] = '{C_START, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0,  17, 8'h00, 1'b1, 2'b11};
    vecs[3] = '{C_WRITE, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 145, 8'h00, 1'b0, 2'b10};
    vecs[4] = '{C_START, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1,  17, 8'h00, 1'b0, 2'b11};
    vecs[5] = '{C_WRITE, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 145, 8'h00, 1'b1, 2'b10};
    vecs[6] = '{C_READ,  8'h00, 1'b1, 8'h3C, 1'b1, 1'b0, 145, 8'h3C, 1'b1, 2'b10};
    vecs[7] = '{C_READ,  8'hFF, 1'b0, 8'hC3, 1'b0, 1'b0, 145, 8'hC3, 1'b1, 2'b11};
    vecs[8] = '{C_STOP,  8'h00, 1'b0, 8'h00, 1'b1, 1'b0,  17, 8'hC3, 1'b1, 2'b00};

    // Reset values, held and after release
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_held", 32'({scl_oe, sda_oe, cmd_ready, busy, done, rx_ack}), 32'b001001);
    rst_n = 1'b1;
    @(posedge clk_in); #1;
    chk("reset_release", 32'({scl_oe, sda_oe, cmd_ready, busy, done, rx_ack}), 32'b001001);
    chk("reset_rx_data", 32'(rx_data), 32'h00);

    // Abort mid-WRITE: reset must release the lines asynchronously
    cmd = C_WRITE; tx_data = 8'h00; cmd_valid = 1'b1;
    @(posedge clk_in); #1;
    cmd_valid = 1'b0;
    repeat (6) @(posedge clk_in);
    #1;
    chk("pre_abort", 32'({busy, scl_oe, sda_oe}), 32'b101);
    rst_n = 1'b0;
    #1;
    chk("abort_async", 32'({scl_oe, sda_oe, cmd_ready, busy}), 32'b0010);
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    @(posedge clk_in); #1;
    chk("abort_idle", 32'({scl_oe, sda_oe, cmd_ready, busy, rx_ack}), 32'b00101);
    model_reset();

    // Directed table
    for (int v = 0; v < 9; v++) begin
      run_cmd(vecs[v].c, vecs[v].d, vecs[v].nk, vecs[v].sb, vecs[v].sa, vecs[v].hold);
      chk($sformatf("vec%0d_latency", v), 32'(got_lat), 32'(vecs[v].lat));
      chk($sformatf("vec%0d_rx", v), 32'({rx_data, rx_ack}), 32'({vecs[v].rxd, vecs[v].rxa}));
      chk($sformatf("vec%0d_lines", v), 32'({scl_oe, sda_oe}), 32'(vecs[v].lines));
    end

    // Random command stream
    for (int r = 0; r < 25; r++) begin
      run_cmd(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 8'($urandom),
              1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
